mem_wb_elastic_reg: RTL and testbench
=====================================

# mem_wb_elastic_reg

Parametrised MEM/WB stage register for the pipelined MIPS core. It is a successor to the plain always-load stage register. It carries the writeback payload (regwrite, memtoreg, read data, ALU result, destination register) from MEM to WB with a valid/ready handshake. A two-entry elastic buffer gives full throughput with a registered ready, plus a synchronous flush that turns in-flight entries into bubbles.

## Interface
Parameters:
- DATA_W, 32, width of readdata and aluout fields
- REG_ADDR_W, 5, width of destination register index

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- flush  in  1  discard all held entries and the current input
- in_valid  in  1  MEM stage presents a payload
- in_ready  out  1  stage can accept; registered
- regwriM  in  1  register-write enable
- memtoregM  in  1  writeback select
- readdataM  in  DATA_W  memory read data
- aluoutM  in  DATA_W  ALU result
- wriregM  in  REG_ADDR_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  WB consumes head
- regwriW, memtoregW, readdataW, aluoutW, wriregW  out  matching widths  head-entry payload

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready. Strict FIFO order. No payload is dropped or duplicated except by flush or reset.
- State machine (EMPTY, ONE, TWO). The head register drives the outputs. The skid register is used only in TWO.
  - EMPTY: in-transfer -> ONE, payload loaded into head.
  - ONE: in-only -> TWO (payload to skid). Out-only -> EMPTY. In and out together -> ONE, head replaced by new payload.
  - TWO: in_ready=0. Out-transfer -> ONE, skid moves to head.
- in_ready = (state != TWO), driven from a state register.
- out_valid = (state != EMPTY).
- Bubble rule: regwriW and memtoregW are forced to 0 whenever out_valid=0, so a bubble never writes the register file. Data fields are don't-care but hold their last value.
- Stability: while out_valid && !out_ready, all W outputs are held constant.
- flush (rst_n=1): next state EMPTY. Input presented in the same cycle is discarded even if in_valid=1. flush overrides simultaneous in/out transfers; the head is not considered consumed.
- Reset: state EMPTY, all W outputs 0, out_valid 0, in_ready 1. Reset takes priority over flush. Reset mid-transfer discards everything.

## Timing
- Latency: a payload accepted at edge N appears on W outputs with out_valid=1 after edge N (visible in cycle N+1) when the buffer was empty or drained that cycle.
- Throughput: one transfer per cycle sustained with out_ready=1.
- Back-pressure: at most two accepted payloads held. in_ready falls the cycle after the second entry is written and rises the cycle after the first out-transfer from TWO.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Configuration
- MEM_WB_FWD_EN defined: adds outputs fwd_valid (1), fwd_reg (REG_ADDR_W) and fwd_data (DATA_W) for the hazard unit.
  - fwd_valid = out_valid && regwriW && (wriregW != 0).
  - fwd_reg = wriregW.
  - fwd_data = memtoregW ? readdataW : aluoutW.
  - Pure function of the head register, zero added latency. Reset value of fwd_valid is 0.
- Undefined: ports absent, no forwarding logic.

## Structure
- Shared package mips_pipe_pkg holds:
  - the state enum (EMPTY, ONE, TWO);
  - a packed struct for the writeback payload (regwri, memtoreg, readdata, aluout, wrireg), parametrised by DATA_W and REG_ADDR_W via localparam widths;
  - the constant ZERO_REG = 0.
- One sub-module, pipe_elastic_buf: generic two-entry elastic buffer over a PAYLOAD_W vector with the valid/ready, flush and reset rules. The top module packs and unpacks fields, applies the bubble rule, and contains the optional forwarding logic.

## Test plan
- Reset: hold rst_n=0 3 cycles with in_valid=1 -> out_valid=0, regwriW=0, all W outputs 0, in_ready=1. First cycle after release: accept aluoutM=0x1234, wriregM=5 -> next cycle out_valid=1, aluoutW=0x1234, wriregW=5.
- Streaming: 8 back-to-back payloads aluout=1..8, out_ready=1 -> outputs 1..8 on consecutive cycles, in_ready stays 1.
- Back-pressure: out_ready=0, push A=0xA, B=0xB -> in_ready=0 after B, outputs hold A. Release out_ready -> A then B, C accepted the cycle in_ready returns.
- Flush: buffer in TWO with in_valid=1 and flush=1 -> next cycle out_valid=0, regwriW=0, in_ready=1, and none of the three payloads ever appear.
- Bubble gating: stimulus with in_valid=0, regwriM=1 -> regwriW stays 0.
- Forwarding (MEM_WB_FWD_EN):
  - head memtoreg=1, readdata=0xDEAD, wrireg=7, regwri=1 -> fwd_valid=1, fwd_reg=7, fwd_data=0xDEAD.
  - wrireg=0 -> fwd_valid=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stage registers.
package mips_pipe_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 5;
  localparam int ZERO_REG      = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Writeback payload at the default core widths; stage registers that are
  // built with other widths declare a locally sized struct with this layout.
  typedef struct packed {
    logic                     regwri;
    logic                     memtoreg;
    logic [WB_DATA_W-1:0]     readdata;
    logic [WB_DATA_W-1:0]     aluout;
    logic [WB_REG_ADDR_W-1:0] wrireg;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_elastic_buf.sv
// Two-entry elastic buffer: head drives the output, skid only holds a second
// entry while the consumer stalls. Ready and valid decode the state register.
module pipe_elastic_buf
  import mips_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] data_o,
  output buf_state_e           state_o
);

  buf_state_e           state_q;
  logic [PAYLOAD_W-1:0] head_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 in_xfer;
  logic                 out_xfer;

  // Handshake: a beat moves on an edge where valid and ready are both high;
  // valid never waits on ready, and both ready and valid come from state_q.
  assign in_ready_o  = (state_q != ST_TWO);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_xfer     = in_valid_i && in_ready_o;
  assign out_xfer    = out_valid_o && out_ready_i;
  assign data_o      = head_q;
  assign state_o     = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      // Head data is kept so the W data fields hold their last value.
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            head_q  <= data_i;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              skid_q  <= data_i;
              state_q <= ST_TWO;
            end
            2'b01: state_q <= ST_EMPTY;
            2'b11: head_q  <= data_i;
            default: ;
          endcase
        end
        ST_TWO: begin
          if (out_xfer) begin
            head_q  <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB stage register with valid/ready handshake and synchronous flush.
// Define MEM_WB_FWD_EN to add the fwd_valid/fwd_reg/fwd_data hazard-unit taps.
module mem_wb_elastic_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  regwriM,
  input  logic                  memtoregM,
  input  logic [DATA_W-1:0]     readdataM,
  input  logic [DATA_W-1:0]     aluoutM,
  input  logic [REG_ADDR_W-1:0] wriregM,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  regwriW,
  output logic                  memtoregW,
  output logic [DATA_W-1:0]     readdataW,
  output logic [DATA_W-1:0]     aluoutW,
  output logic [REG_ADDR_W-1:0] wriregW
`ifdef MEM_WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  typedef struct packed {
    logic                  regwri;
    logic                  memtoreg;
    logic [DATA_W-1:0]     readdata;
    logic [DATA_W-1:0]     aluout;
    logic [REG_ADDR_W-1:0] wrireg;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  payload_t   in_pl;
  payload_t   head_pl;
  buf_state_e buf_state;

  assign in_pl.regwri   = regwriM;
  assign in_pl.memtoreg = memtoregM;
  assign in_pl.readdata = readdataM;
  assign in_pl.aluout   = aluoutM;
  assign in_pl.wrireg   = wriregM;

  pipe_elastic_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (in_pl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (head_pl),
    .state_o     (buf_state)
  );

  // A bubble must never write the register file, whatever stale head holds.
  assign regwriW   = head_pl.regwri   && (buf_state != ST_EMPTY);
  assign memtoregW = head_pl.memtoreg && (buf_state != ST_EMPTY);
  assign readdataW = head_pl.readdata;
  assign aluoutW   = head_pl.aluout;
  assign wriregW   = head_pl.wrireg;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = out_valid && regwriW && (wriregW != REG_ADDR_W'(ZERO_REG));
  assign fwd_reg   = wriregW;
  assign fwd_data  = memtoregW ? readdataW : aluoutW;
`endif

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Directed bench for mem_wb_elastic_reg: reset, streaming, back-pressure,
// flush, bubble gating, reset priority and (with MEM_WB_FWD_EN) forwarding.
module tb_mem_wb_elastic_reg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  regwriM;
  logic                  memtoregM;
  logic [DATA_W-1:0]     readdataM;
  logic [DATA_W-1:0]     aluoutM;
  logic [REG_ADDR_W-1:0] wriregM;
  logic                  out_valid;
  logic                  out_ready;
  logic                  regwriW;
  logic                  memtoregW;
  logic [DATA_W-1:0]     readdataW;
  logic [DATA_W-1:0]     aluoutW;
  logic [REG_ADDR_W-1:0] wriregW;
`ifdef MEM_WB_FWD_EN
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_reg;
  logic [DATA_W-1:0]     fwd_data;
`endif

  int n_checks = 0;
  int n_bad    = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_wb_elastic_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .regwriM   (regwriM),
    .memtoregM (memtoregM),
    .readdataM (readdataM),
    .aluoutM   (aluoutM),
    .wriregM   (wriregM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .regwriW   (regwriW),
    .memtoregW (memtoregW),
    .readdataW (readdataW),
    .aluoutW   (aluoutW),
    .wriregW   (wriregW)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] alu,
                       input logic [REG_ADDR_W-1:0] wr);
    in_valid  = v;
    regwriM   = rw;
    memtoregM = m2r;
    readdataM = rd;
    aluoutM   = alu;
    wriregM   = wr;
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_regwriW"},   32'(regwriW),   32'd0);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h5555, 32'h99, 5'd9);

    // reset held 3 cycles with in_valid=1
    repeat (3) tick();
    check_empty("rst");
    check_eq("rst_memtoregW", 32'(memtoregW), 32'd0);
    check_eq("rst_aluoutW",   aluoutW,        32'd0);
    check_eq("rst_readdataW", readdataW,      32'd0);
    check_eq("rst_wriregW",   32'(wriregW),   32'd0);

    // first accept after release
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h1234, 5'd5);
    tick();
    check_eq("first_out_valid", 32'(out_valid), 32'd1);
    check_eq("first_aluoutW",   aluoutW,        32'h1234);
    check_eq("first_wriregW",   32'(wriregW),   32'd5);
    check_eq("first_regwriW",   32'(regwriW),   32'd1);
    out_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h7777, 5'd6);
    tick();
    check_empty("drain");
    check_eq("drain_hold_aluoutW", aluoutW, 32'h1234);

    // streaming: 8 back-to-back payloads
    for (int i = 1; i <= 8; i++) exp_q.push_back(DATA_W'(i));
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, DATA_W'(i), REG_ADDR_W'(i));
      tick();
      check_eq("stream_in_ready",  32'(in_ready),  32'd1);
      check_eq("stream_out_valid", 32'(out_valid), 32'd1);
      check_eq("stream_aluoutW",   aluoutW,        exp_q.pop_front());
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    check_empty("stream_end");

    // back-pressure: A, B fill the buffer; C waits for in_ready
    exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hA, 5'd3);
    tick();
    check_eq("bp_a_in_ready", 32'(in_ready), 32'd1);
    check_eq("bp_a_aluoutW",  aluoutW,       exp_q[0]);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hB, 5'd4);
    tick();
    check_eq("bp_b_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_b_aluoutW",  aluoutW,       exp_q[0]);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC, 5'd8);
    tick();
    check_eq("bp_hold_in_ready",  32'(in_ready),  32'd0);
    check_eq("bp_hold_out_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_aluoutW",   aluoutW,        exp_q[0]);
    check_eq("bp_hold_wriregW",   32'(wriregW),   32'd3);
    out_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    check_eq("bp_b_head",      aluoutW,       exp_q[0]);
    check_eq("bp_rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    void'(exp_q.pop_front());
    check_eq("bp_c_head",        aluoutW,        exp_q[0]);
    check_eq("bp_c_out_valid",   32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    void'(exp_q.pop_front());
    check_empty("bp_end");

    // flush with buffer in TWO and a third payload presented
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h11, 5'd1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h22, 5'd2);
    tick();
    check_eq("fl_pre_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h33, 5'd3);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check_empty("flush");
    check_eq("flush_memtoregW", 32'(memtoregW), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd0);
    repeat (3) begin
      tick();
      check_eq("flush_stay_out_valid", 32'(out_valid), 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h44, 5'd4);
    tick();
    check_eq("flush_next_aluoutW", aluoutW, 32'h44);

    // bubble gating: regwriM high with in_valid low
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF, 32'hFFFF, 5'd31);
    repeat (2) begin
      tick();
      check_eq("bubble_regwriW",   32'(regwriW),   32'd0);
      check_eq("bubble_memtoregW", 32'(memtoregW), 32'd0);
    end

    // reset beats a simultaneous flush and discards held entries
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd5);
    tick();
    tick();
    rst_n = 1'b0; flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    check_empty("rst_mid");
    check_eq("rst_mid_aluoutW", aluoutW, 32'd0);

`ifdef MEM_WB_FWD_EN
    check_eq("fwd_rst_valid", 32'(fwd_valid), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 5'd7);
    tick();
    check_eq("fwd_valid", 32'(fwd_valid), 32'd1);
    check_eq("fwd_reg",   32'(fwd_reg),   32'd7);
    check_eq("fwd_data",  fwd_data,       32'hDEAD);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hDEAD, 32'hBEEF, 5'd9);
    tick();
    check_eq("fwd_alu_data",  fwd_data,       32'hBEEF);
    check_eq("fwd_alu_valid", 32'(fwd_valid), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 5'd0);
    tick();
    check_eq("fwd_zero_reg_valid", 32'(fwd_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    check_eq("fwd_bubble_valid", 32'(fwd_valid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
